// File: rtl/halfband_decim_mac_pkg.sv
// Shared definitions for the halfband decimator: width helper, FSM state
// encoding and the default 15-tap coefficient set.
package hb_pkg;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam int DEF_WIDTH  = 18;
    localparam int DEF_LENGTH = 15;
    localparam int DEF_NPAIR  = (DEF_LENGTH + 1) / 4;

    // Non-zero outer taps h[0], h[2], h[4], h[6] in 0sWIDTH format. The centre
    // tap (0.5) is applied as a shift and the odd taps are structurally zero.
    localparam logic signed [DEF_WIDTH-1:0] COEF [DEF_NPAIR] = '{
        -18'sd322, 18'sd3144, -18'sd15695, 18'sd78408
    };

    // Flattened form, pair k occupies bits [k*WIDTH +: WIDTH].
    localparam logic [DEF_NPAIR*DEF_WIDTH-1:0] COEF_FLAT_DEFAULT =
        {COEF[3], COEF[2], COEF[1], COEF[0]};

endpackage

// File: rtl/halfband_decim_mac_if.sv
// Sample-in / sample-out bundle of the halfband decimator plus status flags.
interface halfband_decim_mac_if #(
    parameter int WIDTH = 18
);
    logic                    in_en;
    logic signed [WIDTH-1:0] x_in;
    logic                    byp;
    logic signed [WIDTH-1:0] y;
    logic                    y_valid;
    logic                    sat;
    logic                    overrun;
    logic                    busy;

    // Source of samples / consumer of results.
    modport master (
        output in_en, x_in, byp,
        input  y, y_valid, sat, overrun, busy
    );

    // The filter itself.
    modport slave (
        input  in_en, x_in, byp,
        output y, y_valid, sat, overrun, busy
    );
endinterface

// File: rtl/halfband_decim_mac_preadd_mult.sv
// Symmetric-pair pre-adder followed by a registered signed multiplier; maps
// onto a single DSP slice (pre-adder, multiplier, output register).
module hb_preadd_mult #(
    parameter int WIDTH = 18
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic signed [WIDTH-1:0]   a_i,
    input  logic signed [WIDTH-1:0]   b_i,
    input  logic signed [WIDTH-1:0]   coef_i,
    output logic signed [2*WIDTH:0]   prod_o
);

    localparam int PW = 2 * WIDTH + 1;

    logic signed [WIDTH:0]  sum_w;
    logic signed [PW-1:0]   prod_d;
    logic signed [PW-1:0]   prod_q;

    // Full-precision pre-add (one guard bit) and product, no pre-scaling.
    always_comb begin
        sum_w  = (WIDTH + 1)'(a_i) + (WIDTH + 1)'(b_i);
        prod_d = PW'(sum_w) * PW'(coef_i);
    end

    // Product register: free-running, the controller knows its one-cycle delay.
    always_ff @(posedge clk) begin
        if (srst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/halfband_decim_mac.sv
// Symmetric halfband decimate-by-2 FIR using one time-shared pre-add
// multiplier. One output is computed per two inputs; the centre tap is a
// shift, zero taps are skipped, results are rounded half-up and saturated.
module halfband_decim_mac
    import hb_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int LENGTH    = 15,   // must be 4K-1, K >= 2
    parameter int OUT_PHASE = 1,
    parameter logic [((LENGTH + 1) / 4) * WIDTH - 1:0] COEF_FLAT = COEF_FLAT_DEFAULT
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    halfband_decim_mac_if.slave  bus
);

    localparam int NPAIR  = (LENGTH + 1) / 4;
    localparam int CENTRE = (LENGTH - 1) / 2;
    localparam int PW     = 2 * WIDTH + 1;
    localparam int ACCW   = 2 * WIDTH + 1 + clog2(NPAIR + 1);
    localparam int OW     = ACCW - WIDTH;
    localparam int KW     = (clog2(NPAIR) < 1) ? 1 : clog2(NPAIR);
    localparam logic TRIG_PH = 1'(OUT_PHASE);

    localparam logic signed [ACCW-1:0]  HALF_LSB = ACCW'(1) << (WIDTH - 1);
    localparam logic signed [WIDTH-1:0] OUT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [OW-1:0]    LIM_MAX  = OW'(OUT_MAX);
    localparam logic signed [OW-1:0]    LIM_MIN  = OW'(OUT_MIN);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    ph_q, ph_d;
    logic signed [WIDTH-1:0] x_q [LENGTH];
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic                    sat_q, sat_d;
    logic                    y_valid_q, y_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [WIDTH-1:0] tap_lo   [NPAIR];
    logic signed [WIDTH-1:0] tap_hi   [NPAIR];
    logic signed [WIDTH-1:0] coef_tab [NPAIR];
    logic signed [PW-1:0]    prod_w;
    logic signed [ACCW-1:0]  centre_w;
    logic signed [ACCW-1:0]  rnd_w;
    logic signed [OW-1:0]    scaled_w;
    logic signed [WIDTH-1:0] y_sat_w;
    logic                    clip_w;
    logic                    busy_w;
    logic                    trigger_w;

    // Per-pair operand taps x[2k] / x[LENGTH-1-2k] and coefficient slices.
    for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
        assign tap_lo[gi]   = x_q[2 * gi];
        assign tap_hi[gi]   = x_q[LENGTH - 1 - 2 * gi];
        assign coef_tab[gi] = COEF_FLAT[gi * WIDTH +: WIDTH];
    end

    assign busy_w    = (state_q != ST_IDLE);
    assign trigger_w = bus.in_en && !bus.byp && (ph_q == TRIG_PH);

    // Delay line shifts on every strobe regardless of mode or FSM state.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                x_q[i] <= '0;
            end
        end else if (bus.in_en) begin
            x_q[0] <= bus.x_in;
            for (int i = 1; i < LENGTH; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    hb_preadd_mult #(.WIDTH(WIDTH)) u_mult (
        .clk    (sys_clk),
        .srst   (reset),
        .a_i    (tap_lo[k_q]),
        .b_i    (tap_hi[k_q]),
        .coef_i (coef_tab[k_q]),
        .prod_o (prod_w)
    );

    // Phase bit: held at 0 in bypass so decimation restarts on a known phase.
    always_comb begin
        ph_d = ph_q;
        if (bus.byp) begin
            ph_d = 1'b0;
        end else if (bus.in_en) begin
            ph_d = ~ph_q;
        end
    end

    // FSM next state: bypass and strobes override the normal MAC sequence;
    // a strobe during a computation aborts it, or restarts it if it triggers.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            ST_IDLE: begin
                k_d = '0;
            end
            ST_MAC: begin
                if (k_q == KW'(NPAIR - 1)) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
        if (bus.byp) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end else if (trigger_w) begin
            state_d = ST_MAC;
            k_d     = '0;
        end else if (bus.in_en && busy_w) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end
    end

    // Accumulator: seeded with the 0.5 centre term, then sums the products
    // trailing one cycle behind the tap counter (last one lands in DRAIN).
    always_comb begin
        centre_w = ACCW'(x_q[CENTRE]) <<< (WIDTH - 1);
        acc_d    = acc_q;
        if (state_q == ST_MAC && k_q == '0) begin
            acc_d = centre_w;
        end else if (state_q == ST_MAC || state_q == ST_DRAIN) begin
            acc_d = acc_q + ACCW'(prod_w);
        end
    end

    // Round half-up to the output LSB, then clip to the signed output range.
    always_comb begin
        rnd_w    = acc_q + HALF_LSB;
        scaled_w = OW'(rnd_w >>> WIDTH);
        y_sat_w  = WIDTH'(scaled_w);
        clip_w   = 1'b0;
        if (scaled_w > LIM_MAX) begin
            y_sat_w = OUT_MAX;
            clip_w  = 1'b1;
        end else if (scaled_w < LIM_MIN) begin
            y_sat_w = OUT_MIN;
            clip_w  = 1'b1;
        end
    end

    // Output register and flags; a strobe landing in OUT suppresses the result.
    always_comb begin
        y_d       = y_q;
        sat_d     = sat_q;
        y_valid_d = 1'b0;
        overrun_d = overrun_q;
        if (bus.in_en && busy_w) begin
            overrun_d = 1'b1;
        end
        if (bus.byp) begin
            if (bus.in_en) begin
                y_d       = bus.x_in;
                sat_d     = 1'b0;
                y_valid_d = 1'b1;
            end
        end else if (state_q == ST_OUT && !bus.in_en) begin
            y_d       = y_sat_w;
            sat_d     = clip_w;
            y_valid_d = 1'b1;
        end
    end

    // State registers for control, datapath and outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            ph_q      <= 1'b0;
            acc_q     <= '0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ph_q      <= ph_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            sat_q     <= sat_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sat     = sat_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = busy_w;

endmodule
